// File: rtl/eth_rst_pkg.sv
// Shared definitions for the Ethernet bring-up sequencer.
// Contents:
//   state_t  - sequencer state, fixed 3-bit encoding 0..5 (visible on state_o)
//   outs_t   - output tuple {phy_rstn, rgmii_rstn, mac_rst, ready}
//   DEF_*    - default dwell constants (125 MHz system clock)
//   outs_for - output tuple driven while in a given state
package eth_rst_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_PHY_RST   = 3'd2,
    ST_PHY_WAKE  = 3'd3,
    ST_RGMII_UP  = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam int DEF_CNT_W           = 20;
  localparam int DEF_PHY_RST_CYC     = 125000;
  localparam int DEF_PHY_WAKE_CYC    = 65536;
  localparam int DEF_MAC_DLY_CYC     = 65536;
  localparam int DEF_LOCK_STABLE_CYC = 256;

  typedef struct packed {
    logic phy_rstn;
    logic rgmii_rstn;
    logic mac_rst;
    logic ready;
  } outs_t;

  localparam outs_t OUTS_HELD  = 4'b0010;
  localparam outs_t OUTS_WAKE  = 4'b1010;
  localparam outs_t OUTS_RGMII = 4'b1110;
  localparam outs_t OUTS_RUN   = 4'b1101;

  function automatic outs_t outs_for(state_t s);
    case (s)
      ST_PHY_WAKE: outs_for = OUTS_WAKE;
      ST_RGMII_UP: outs_for = OUTS_RGMII;
      ST_RUN:      outs_for = OUTS_RUN;
      default:     outs_for = OUTS_HELD;
    endcase
  endfunction

endpackage

// File: rtl/rst_dwell_timer.sv
// Loadable down-counter used to time each bring-up stage.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset (count clears to 0)
//   load       - load load_val this cycle (takes priority over decrement)
//   load_val   - value to load
//   done       - count == 0; the counter holds at 0 and never wraps
module rst_dwell_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/eth_bringup_seq.sv
// Staged Ethernet bring-up sequencer: releases PHY hard reset, then RGMII
// reset, then MAC reset, with programmable dwell times, gated by PLL lock.
// Build option: define LOCK_FILTER_EN to require LOCK_STABLE_CYC consecutive
// pll_lock-high cycles before leaving WAIT_LOCK (otherwise first high cycle).
// Ports:
//   clk, rstn     - clock, synchronous active-low reset
//   pll_lock      - PLL locked (synchronous to clk)
//   soft_rst_req  - one-cycle request for a full re-sequence
//   phy_rstn      - PHY hard reset, active-low
//   rgmii_rstn    - RGMII reset, active-low
//   mac_rst       - MAC reset, active-high
//   ready         - high only in RUN
//   soft_rst_ack  - one-cycle pulse on RUN entry after a soft request
//   state_o       - current state (debug)
module eth_bringup_seq
  import eth_rst_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int PHY_RST_CYC     = DEF_PHY_RST_CYC,
  parameter int PHY_WAKE_CYC    = DEF_PHY_WAKE_CYC,
  parameter int MAC_DLY_CYC     = DEF_MAC_DLY_CYC,
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       phy_rstn,
  output logic       rgmii_rstn,
  output logic       mac_rst,
  output logic       ready,
  output logic       soft_rst_ack,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] PHY_RST_LD  = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] PHY_WAKE_LD = CNT_W'(PHY_WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] MAC_DLY_LD  = CNT_W'(MAC_DLY_CYC - 1);

  state_t           state;
  outs_t            outs;
  logic             pending;
  logic             ack;
  logic             lock_met;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

`ifdef LOCK_FILTER_EN
  localparam int LOCK_W = $clog2(LOCK_STABLE_CYC + 1);
  logic [LOCK_W-1:0] lock_cnt;

  // Consecutive-high counter, saturating at LOCK_STABLE_CYC.
  always_ff @(posedge clk) begin
    if (!rstn || !pll_lock) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_W'(LOCK_STABLE_CYC)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // The current high cycle counts too, so exit on the edge sampling the
  // LOCK_STABLE_CYC-th consecutive high.
  assign lock_met = pll_lock && (lock_cnt >= LOCK_W'(LOCK_STABLE_CYC - 1));
`else
  assign lock_met = pll_lock;
`endif

  // Timer loads on the same edge as the transition into the timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PHY_RST_LD;
    case (state)
      ST_WAIT_LOCK: tmr_load = lock_met;
      ST_PHY_RST: begin
        tmr_load = pll_lock && tmr_done;
        tmr_val  = PHY_WAKE_LD;
      end
      ST_PHY_WAKE: begin
        tmr_load = pll_lock && tmr_done;
        tmr_val  = MAC_DLY_LD;
      end
      ST_RUN:  tmr_load = pll_lock && (soft_rst_req || pending);
      default: tmr_load = 1'b0;
    endcase
  end

  rst_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_RST;
      outs    <= OUTS_HELD;
      pending <= 1'b0;
      ack     <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (state != ST_RST && state != ST_WAIT_LOCK && !pll_lock) begin
        // Lock loss wins over everything; a coincident request stays pending.
        state   <= ST_WAIT_LOCK;
        outs    <= outs_for(ST_WAIT_LOCK);
        pending <= pending | soft_rst_req;
      end else begin
        case (state)
          ST_RST: begin
            state   <= ST_WAIT_LOCK;
            outs    <= outs_for(ST_WAIT_LOCK);
            pending <= pending | soft_rst_req;
          end
          ST_WAIT_LOCK: begin
            pending <= pending | soft_rst_req;
            if (lock_met) begin
              state <= ST_PHY_RST;
              outs  <= outs_for(ST_PHY_RST);
            end
          end
          ST_PHY_RST: begin
            pending <= pending | soft_rst_req;
            if (tmr_done) begin
              state <= ST_PHY_WAKE;
              outs  <= outs_for(ST_PHY_WAKE);
            end
          end
          ST_PHY_WAKE: begin
            pending <= pending | soft_rst_req;
            if (tmr_done) begin
              state <= ST_RGMII_UP;
              outs  <= outs_for(ST_RGMII_UP);
            end
          end
          ST_RGMII_UP: begin
            if (tmr_done) begin
              // Ack only requests seen before this edge; one arriving on the
              // entry edge is kept pending and restarts the sequence from RUN.
              state   <= ST_RUN;
              outs    <= outs_for(ST_RUN);
              ack     <= pending;
              pending <= soft_rst_req;
            end else begin
              pending <= pending | soft_rst_req;
            end
          end
          ST_RUN: begin
            if (soft_rst_req || pending) begin
              state   <= ST_PHY_RST;
              outs    <= outs_for(ST_PHY_RST);
              pending <= 1'b1;
            end
          end
          default: begin
            state <= ST_RST;
            outs  <= OUTS_HELD;
          end
        endcase
      end
    end
  end

  assign phy_rstn     = outs.phy_rstn;
  assign rgmii_rstn   = outs.rgmii_rstn;
  assign mac_rst      = outs.mac_rst;
  assign ready        = outs.ready;
  assign soft_rst_ack = ack;
  assign state_o      = state;

endmodule

// File: tb/tb_eth_bringup_seq.sv
// Directed bench for eth_bringup_seq with short dwell times (4/3/2, lock
// filter 5). Observed vector: {state_o, phy_rstn, rgmii_rstn, mac_rst, ready,
// soft_rst_ack}. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, reflecting that edge.
module tb_eth_bringup_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       phy_rstn;
  logic       rgmii_rstn;
  logic       mac_rst;
  logic       ready;
  logic       soft_rst_ack;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  eth_bringup_seq #(
    .CNT_W           (20),
    .PHY_RST_CYC     (4),
    .PHY_WAKE_CYC    (3),
    .MAC_DLY_CYC     (2),
    .LOCK_STABLE_CYC (5)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .phy_rstn     (phy_rstn),
    .rgmii_rstn   (rgmii_rstn),
    .mac_rst      (mac_rst),
    .ready        (ready),
    .soft_rst_ack (soft_rst_ack),
    .state_o      (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic [2:0] st,
                          input logic p, input logic r, input logic m,
                          input logic rd, input logic a);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {state_o, phy_rstn, rgmii_rstn, mac_rst, ready, soft_rst_ack};
    exp = {st, p, r, m, rd, a};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Raise lock from WAIT_LOCK (lock previously low) until PHY_RST is entered.
  task automatic lock_entry(input string tag);
    pll_lock = 1'b1;
`ifdef LOCK_FILTER_EN
    repeat (4) begin
      tick();
      expect_o({tag, "_filt"}, 3'd1, 0, 0, 1, 0, 0);
    end
`endif
    tick();
    expect_o({tag, "_enter"}, 3'd2, 0, 0, 1, 0, 0);
  endtask

  // Called right after the edge that entered PHY_RST; walks 4/3/2 to RUN.
  task automatic seq(input string tag, input logic ack, input logic hold_soft);
    soft_rst_req = hold_soft;
    tick();
    soft_rst_req = 1'b0;
    expect_o({tag, "_phyrst1"}, 3'd2, 0, 0, 1, 0, 0);
    tick();
    tick();
    expect_o({tag, "_phyrst3"}, 3'd2, 0, 0, 1, 0, 0);
    tick();
    expect_o({tag, "_wake0"}, 3'd3, 1, 0, 1, 0, 0);
    tick();
    tick();
    expect_o({tag, "_wake2"}, 3'd3, 1, 0, 1, 0, 0);
    tick();
    expect_o({tag, "_rgmii0"}, 3'd4, 1, 1, 1, 0, 0);
    tick();
    expect_o({tag, "_rgmii1"}, 3'd4, 1, 1, 1, 0, 0);
    tick();
    expect_o({tag, "_run0"}, 3'd5, 1, 1, 0, 1, ack);
    tick();
    expect_o({tag, "_run1"}, 3'd5, 1, 1, 0, 1, 0);
  endtask

  // From RUN: drop lock one cycle, then relock into PHY_RST.
  task automatic bounce_lock(input string tag);
    pll_lock = 1'b0;
    tick();
    expect_o({tag, "_loss"}, 3'd1, 0, 0, 1, 0, 0);
    lock_entry(tag);
  endtask

  initial begin
    rstn         = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) tick();
    expect_o("reset", 3'd0, 0, 0, 1, 0, 0);

    // Cold start
    rstn = 1'b1;
    tick();
    expect_o("rst_exit", 3'd1, 0, 0, 1, 0, 0);
    tick();
    expect_o("no_lock_hold", 3'd1, 0, 0, 1, 0, 0);
    lock_entry("cold");
    seq("cold", 1'b0, 1'b0);

    // Lock loss in PHY_WAKE, then full relock sequence
    bounce_lock("ll");
    repeat (4) tick();
    expect_o("ll_in_wake", 3'd3, 1, 0, 1, 0, 0);
    pll_lock = 1'b0;
    tick();
    expect_o("ll_wake_loss", 3'd1, 0, 0, 1, 0, 0);
    lock_entry("ll_relock");
    seq("ll_relock", 1'b0, 1'b0);

    // Soft request in RUN; a second request while pending collapses
    soft_rst_req = 1'b1;
    tick();
    expect_o("soft_run", 3'd2, 0, 0, 1, 0, 0);
    seq("soft_run", 1'b1, 1'b1);

    // Soft request plus lock loss together during PHY_RST
    bounce_lock("both");
    tick();
    soft_rst_req = 1'b1;
    pll_lock     = 1'b0;
    tick();
    soft_rst_req = 1'b0;
    expect_o("both_loss", 3'd1, 0, 0, 1, 0, 0);
    lock_entry("both_relock");
    seq("both_relock", 1'b1, 1'b0);

    // rstn pulse during RGMII_UP with a request pending: no ack afterwards
    bounce_lock("abort");
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    repeat (6) tick();
    expect_o("abort_rgmii", 3'd4, 1, 1, 1, 0, 0);
    rstn     = 1'b0;
    pll_lock = 1'b0;
    tick();
    expect_o("abort_rst", 3'd0, 0, 0, 1, 0, 0);
    rstn = 1'b1;
    tick();
    expect_o("abort_wait", 3'd1, 0, 0, 1, 0, 0);
    lock_entry("abort_relock");
    seq("abort_relock", 1'b0, 1'b0);

    // Soft request coincident with the RUN entry edge
    bounce_lock("edge");
    repeat (8) tick();
    expect_o("edge_rgmii1", 3'd4, 1, 1, 1, 0, 0);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_o("edge_run_noack", 3'd5, 1, 1, 0, 1, 0);
    tick();
    expect_o("edge_restart", 3'd2, 0, 0, 1, 0, 0);
    seq("edge_reseq", 1'b1, 1'b0);

`ifdef LOCK_FILTER_EN
    // Broken lock run: 4 high, 1 low, then 5 high
    pll_lock = 1'b0;
    tick();
    expect_o("filt_loss", 3'd1, 0, 0, 1, 0, 0);
    pll_lock = 1'b1;
    repeat (4) begin
      tick();
      expect_o("filt_run4", 3'd1, 0, 0, 1, 0, 0);
    end
    pll_lock = 1'b0;
    tick();
    expect_o("filt_gap", 3'd1, 0, 0, 1, 0, 0);
    lock_entry("filt_run5");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
